// File: rtl/btn_conditioner.sv
// btn_conditioner: push-button input conditioner.
//
// Each raw button pad goes through its own synchronizer, debounce FSM and
// auto-repeat timer. The channels share no logic.
//
// Ports:
//   clk     board clock; all flops update on the rising edge
//   rst     asynchronous, active-high reset
//   btn_in  raw button levels, 1 = pressed
//   dpb     debounced level per channel
//   scen    one-cycle pulse per accepted press
//   mcen    one-cycle pulse on accepted press and on every auto-repeat

// btn_channel: one button channel.
//
// Ports:
//   clk, rst  as for btn_conditioner
//   btn       raw level of this button
//   dpb       debounced level
//   scen      press pulse
//   mcen      press / auto-repeat pulse
//
// state   | meaning
// --------+---------------------------------------------------------
// INIT    | released and stable
// WQ      | press candidate, counting D stable-high cycles
// PRESSED | held, counting R cycles to the first auto-repeat
// REPEAT  | auto-repeating, one mcen pulse every P cycles
// WR      | release candidate, counting D continuously quiet cycles
module btn_channel #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000,
    parameter int CW              = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic dpb,
    output logic scen,
    output logic mcen
);

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        WQ      = 3'd1,
        PRESSED = 3'd2,
        REPEAT  = 3'd3,
        WR      = 3'd4
    } state_t;

    localparam logic [CW-1:0] D_TC = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] R_TC = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] P_TC = CW'(REPEAT_PERIOD - 1);

    logic [1:0]    sync_q;
    logic          s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          scen_q, scen_d;
    logic          mcen_q, mcen_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn};
        end
    end

    assign s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        scen_d  = 1'b0;
        mcen_d  = 1'b0;
        case (state_q)
            INIT: begin
                cnt_d = '0;
                if (s) begin
                    state_d = WQ;
                end
            end
            WQ: begin
                if (!s) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end else if (cnt_q == D_TC) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    scen_d  = 1'b1;
                    mcen_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = WR;
                    cnt_d   = '0;
                end else if (cnt_q == R_TC) begin
                    state_d = REPEAT;
                    cnt_d   = '0;
                    mcen_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REPEAT: begin
                if (!s) begin
                    state_d = WR;
                    cnt_d   = '0;
                end else if (cnt_q == P_TC) begin
                    cnt_d  = '0;
                    mcen_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR: begin
                // Any high sample restarts the quiet-time count.
                if (s) begin
                    cnt_d = '0;
                end else if (cnt_q == D_TC) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
            scen_q  <= 1'b0;
            mcen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scen_q  <= scen_d;
            mcen_q  <= mcen_d;
        end
    end

    // Decoded from the state register, so it drops to 0 as soon as reset asserts.
    assign dpb  = (state_q == PRESSED) || (state_q == REPEAT) || (state_q == WR);
    assign scen = scen_q;
    assign mcen = mcen_q;

endmodule

module btn_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] dpb,
    output logic [N_BTN-1:0] scen,
    output logic [N_BTN-1:0] mcen
);

    localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_CNT = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
    // The counter only ever holds values up to MAX_CNT-1.
    localparam int CW      = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_conditioner: DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 1) begin : g_bad_delay
        $error("btn_conditioner: REPEAT_DELAY must be at least 1");
    end
    if (REPEAT_PERIOD < 1) begin : g_bad_period
        $error("btn_conditioner: REPEAT_PERIOD must be at least 1");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .CW              (CW)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn_in[i]),
            .dpb  (dpb[i]),
            .scen (scen[i]),
            .mcen (mcen[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with D = 4, R = 10, P = 5.
// Edge numbering: edge 1 is the first rising edge that samples the new
// btn_in value; outputs are sampled 1 ns after each rising edge.
module tb_btn_conditioner;

    logic       clk;
    logic       rst;
    logic [3:0] btn_in;
    logic [3:0] dpb;
    logic [3:0] scen;
    logic [3:0] mcen;

    int n_cmp = 0;
    int n_err = 0;

    btn_conditioner #(
        .N_BTN           (4),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_in),
        .dpb    (dpb),
        .scen   (scen),
        .mcen   (mcen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        btn_in = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        btn_in = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({dpb, scen, mcen} !== 12'h000) begin
                n_err++;
                $display("FAIL reset cycle %0d: got dpb/scen/mcen=%b/%b/%b want 0000/0000/0000",
                         i, dpb, scen, mcen);
            end
        end
        btn_in = 4'b0000;
        rst    = 1'b0;
    endtask

    // Channel 0 held for 30 edges then released.
    task automatic test_clean_press();
        logic [3:0] ed, es, em;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            btn_in = (e <= 30) ? 4'b0001 : 4'b0000;
            tick();
            ed = (e >= 7 && e < 37) ? 4'b0001 : 4'b0000;
            es = (e == 7) ? 4'b0001 : 4'b0000;
            em = (e == 7 || e == 17 || e == 22 || e == 27 || e == 32) ? 4'b0001 : 4'b0000;
            n_cmp++;
            if ({dpb, scen, mcen} !== {ed, es, em}) begin
                n_err++;
                $display("FAIL clean_press edge %0d: got dpb/scen/mcen=%b/%b/%b want %b/%b/%b",
                         e, dpb, scen, mcen, ed, es, em);
            end
        end
    endtask

    // Short glitches on channel 1 must be ignored, then a clean press
    // must take the full debounce time (proves the FSM fell back to INIT).
    task automatic test_bounce();
        logic [3:0] ed, es, em;
        do_reset();
        for (int e = 1; e <= 15; e++) begin
            btn_in = (e <= 3 || e == 5 || e == 6) ? 4'b0010 : 4'b0000;
            tick();
            n_cmp++;
            if ({dpb, scen, mcen} !== 12'h000) begin
                n_err++;
                $display("FAIL bounce edge %0d: got dpb/scen/mcen=%b/%b/%b want 0000/0000/0000",
                         e, dpb, scen, mcen);
            end
        end
        for (int e = 1; e <= 12; e++) begin
            btn_in = 4'b0010;
            tick();
            ed = (e >= 7) ? 4'b0010 : 4'b0000;
            es = (e == 7) ? 4'b0010 : 4'b0000;
            em = es;
            n_cmp++;
            if ({dpb, scen, mcen} !== {ed, es, em}) begin
                n_err++;
                $display("FAIL bounce_repress edge %0d: got dpb/scen/mcen=%b/%b/%b want %b/%b/%b",
                         e, dpb, scen, mcen, ed, es, em);
            end
        end
    endtask

    // Channel 2: held 20 edges, low 2, high 1, low thereafter.
    // The high sample at edge 23 is seen by the FSM at edge 25 and restarts
    // the quiet count there, so INIT is reached at edge 29.
    task automatic test_release_debounce();
        logic [3:0] ed, es, em;
        do_reset();
        for (int e = 1; e <= 36; e++) begin
            btn_in = (e <= 20 || e == 23) ? 4'b0100 : 4'b0000;
            tick();
            ed = (e >= 7 && e < 29) ? 4'b0100 : 4'b0000;
            es = (e == 7) ? 4'b0100 : 4'b0000;
            em = (e == 7 || e == 17 || e == 22) ? 4'b0100 : 4'b0000;
            n_cmp++;
            if ({dpb, scen, mcen} !== {ed, es, em}) begin
                n_err++;
                $display("FAIL release_debounce edge %0d: got dpb/scen/mcen=%b/%b/%b want %b/%b/%b",
                         e, dpb, scen, mcen, ed, es, em);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] ed, es, em;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            btn_in = (e <= 30) ? 4'b1010 : 4'b0000;
            tick();
            ed = (e >= 7 && e < 37) ? 4'b1010 : 4'b0000;
            es = (e == 7) ? 4'b1010 : 4'b0000;
            em = (e == 7 || e == 17 || e == 22 || e == 27 || e == 32) ? 4'b1010 : 4'b0000;
            n_cmp++;
            if ({dpb, scen, mcen} !== {ed, es, em}) begin
                n_err++;
                $display("FAIL simultaneous edge %0d: got dpb/scen/mcen=%b/%b/%b want %b/%b/%b",
                         e, dpb, scen, mcen, ed, es, em);
            end
        end
    endtask

    // Channel 3 reaches REPEAT, reset hits between edges with the button held.
    task automatic test_reset_mid_hold();
        logic [3:0] ed, es, em;
        do_reset();
        for (int e = 1; e <= 19; e++) begin
            btn_in = 4'b1000;
            tick();
            ed = (e >= 7) ? 4'b1000 : 4'b0000;
            es = (e == 7) ? 4'b1000 : 4'b0000;
            em = (e == 7 || e == 17) ? 4'b1000 : 4'b0000;
            n_cmp++;
            if ({dpb, scen, mcen} !== {ed, es, em}) begin
                n_err++;
                $display("FAIL reset_hold_pre edge %0d: got dpb/scen/mcen=%b/%b/%b want %b/%b/%b",
                         e, dpb, scen, mcen, ed, es, em);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({dpb, scen, mcen} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_hold_assert: got dpb/scen/mcen=%b/%b/%b want 0000/0000/0000",
                     dpb, scen, mcen);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 25; e++) begin
            tick();
            ed = (e >= 7) ? 4'b1000 : 4'b0000;
            es = (e == 7) ? 4'b1000 : 4'b0000;
            em = (e == 7 || e == 17 || e == 22) ? 4'b1000 : 4'b0000;
            n_cmp++;
            if ({dpb, scen, mcen} !== {ed, es, em}) begin
                n_err++;
                $display("FAIL reset_hold_post edge %0d: got dpb/scen/mcen=%b/%b/%b want %b/%b/%b",
                         e, dpb, scen, mcen, ed, es, em);
            end
        end
        btn_in = 4'b0000;
    endtask

    initial begin
        rst    = 1'b1;
        btn_in = 4'b0000;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_debounce();
        test_simultaneous();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
